// File: rtl/spu_if_pkg.sv
// Shared types and helpers for the SPU instruction-fetch stage.
package spu_if_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_RUN  = 2'd1,
    IF_DONE = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_WORD_DFLT = 32'h0;
  localparam int unsigned PERF_W        = 16;

  // fetch_w is a power of two, so masking splits an address into group base and slot offset
  function automatic int unsigned grp_base(input int unsigned addr, input int unsigned fetch_w);
    return addr & ~(fetch_w - 1);
  endfunction

  function automatic int unsigned grp_off(input int unsigned addr, input int unsigned fetch_w);
    return addr & (fetch_w - 1);
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + PERF_W'(1);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Loader / EX / ID facing signals of the fetch stage, grouped with master and slave views.
interface if_fetch_unit_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned FETCH_W = 2
);
  logic                       load_en;
  logic [ADDR_W-1:0]          load_addr;
  logic [INSTR_W-1:0]         instr_in;
  logic                       start;
  logic [ADDR_W-1:0]          last_addr;
  logic                       redirect;
  logic [ADDR_W-1:0]          redirect_pc;
  logic                       stall;
  logic [FETCH_W*INSTR_W-1:0] instr_out;
  logic [FETCH_W-1:0]         slot_valid;
  logic [ADDR_W-1:0]          pc_out;
  logic                       busy;
  logic                       done;
  logic [15:0]                perf_groups;
  logic [15:0]                perf_stalls;
  logic [15:0]                perf_redirects;

  modport slave (
    input  load_en, load_addr, instr_in, start, last_addr, redirect, redirect_pc, stall,
    output instr_out, slot_valid, pc_out, busy, done, perf_groups, perf_stalls, perf_redirects
  );

  modport master (
    output load_en, load_addr, instr_in, start, last_addr, redirect, redirect_pc, stall,
    input  instr_out, slot_valid, pc_out, busy, done, perf_groups, perf_stalls, perf_redirects
  );
endinterface

// File: rtl/if_instr_mem.sv
// Instruction memory: one synchronous write port, one registered read of FETCH_W consecutive words.
module if_instr_mem #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned FETCH_W = 2
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          waddr_i,
  input  logic [INSTR_W-1:0]         wdata_i,
  input  logic                       re_i,
  input  logic [ADDR_W-1:0]          rbase_i,
  output logic [FETCH_W*INSTR_W-1:0] rdata_o
);
  logic [INSTR_W-1:0]         mem_q [2**ADDR_W];
  logic [FETCH_W*INSTR_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Slot 0 lands in the MSBs; the read register doubles as the output hold during stalls.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      for (int unsigned i = 0; i < FETCH_W; i++) begin
        rdata_q[(FETCH_W-1-i)*INSTR_W +: INSTR_W] <= mem_q[rbase_i + ADDR_W'(i)];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/if_fetch_unit.sv
// SPU fetch stage: FSM, PC, slot masking. Define IF_PERF_CNT_EN to build the perf counters.
module if_fetch_unit
  import spu_if_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 10,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        FETCH_W  = 2,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_WORD_DFLT)
) (
  input logic            clk,
  input logic            rst,
  if_fetch_unit_if.slave bus
);
  if_state_e                  state_q, state_d;
  logic [ADDR_W-1:0]          pc_q, pc_d, last_q, last_d, pc_out_q, pc_out_d;
  logic [FETCH_W-1:0]         valid_q, valid_d;
  logic                       end_q, end_d;
  logic                       mem_we, present;
  logic [ADDR_W-1:0]          fetch_base, last_base;
  int unsigned                fetch_off;
  logic [FETCH_W*INSTR_W-1:0] rdata, instr_mux;

  assign last_base = ADDR_W'(grp_base(32'(last_q), FETCH_W));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    last_d     = last_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    end_d      = end_q;
    mem_we     = 1'b0;
    present    = 1'b0;
    fetch_base = pc_q;
    fetch_off  = 0;
    unique case (state_q)
      IF_IDLE, IF_DONE: begin
        mem_we = bus.load_en;
        if (bus.start) begin
          state_d = IF_RUN;
          pc_d    = '0;
          last_d  = bus.last_addr;
          valid_d = '0;
          end_d   = 1'b0;
        end
      end
      IF_RUN: begin
        if (bus.redirect) begin
          present    = 1'b1;
          fetch_base = ADDR_W'(grp_base(32'(bus.redirect_pc), FETCH_W));
          fetch_off  = grp_off(32'(bus.redirect_pc), FETCH_W);
        end else if (!bus.stall) begin
          // The group holding last_q has been released: finish instead of fetching further.
          if (end_q) begin
            state_d = IF_DONE;
            valid_d = '0;
            end_d   = 1'b0;
          end else begin
            present = 1'b1;
          end
        end
      end
      default: state_d = IF_IDLE;
    endcase
    if (present) begin
      pc_out_d = fetch_base;
      pc_d     = fetch_base + ADDR_W'(FETCH_W);
      end_d    = (fetch_base >= last_base);
      for (int unsigned i = 0; i < FETCH_W; i++) begin
        valid_d[i] = (i >= fetch_off) && ((fetch_base + ADDR_W'(i)) <= last_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IF_IDLE;
      pc_q     <= '0;
      last_q   <= '0;
      pc_out_q <= '0;
      valid_q  <= '0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      last_q   <= last_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      end_q    <= end_d;
    end
  end

  if_instr_mem #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .FETCH_W(FETCH_W)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(bus.load_addr),
    .wdata_i(bus.instr_in),
    .re_i   (present),
    .rbase_i(fetch_base),
    .rdata_o(rdata)
  );

  // slot_valid is LSB-first (bit i = slot i) while instr_out carries slot 0 in the MSBs.
  always_comb begin
    instr_mux = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      instr_mux[(FETCH_W-1-i)*INSTR_W +: INSTR_W] =
          valid_q[i] ? rdata[(FETCH_W-1-i)*INSTR_W +: INSTR_W] : NOP_WORD;
    end
  end

  assign bus.instr_out  = instr_mux;
  assign bus.slot_valid = valid_q;
  assign bus.pc_out     = pc_out_q;
  assign bus.busy       = (state_q == IF_RUN);
  assign bus.done       = (state_q == IF_DONE);

`ifdef IF_PERF_CNT_EN
  logic [PERF_W-1:0] groups_q, groups_d, stalls_q, stalls_d, redirs_q, redirs_d;
  logic              in_run, start_ok;

  assign in_run   = (state_q == IF_RUN);
  assign start_ok = ((state_q == IF_IDLE) || (state_q == IF_DONE)) && bus.start;

  always_comb begin
    groups_d = groups_q;
    stalls_d = stalls_q;
    redirs_d = redirs_q;
    if (start_ok) begin
      groups_d = '0;
      stalls_d = '0;
      redirs_d = '0;
    end else if (in_run) begin
      if (present) groups_d = sat_inc(groups_q);
      if (bus.redirect)   redirs_d = sat_inc(redirs_q);
      else if (bus.stall) stalls_d = sat_inc(stalls_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      groups_q <= '0;
      stalls_q <= '0;
      redirs_q <= '0;
    end else begin
      groups_q <= groups_d;
      stalls_q <= stalls_d;
      redirs_q <= redirs_d;
    end
  end

  assign bus.perf_groups    = groups_q;
  assign bus.perf_stalls    = stalls_q;
  assign bus.perf_redirects = redirs_q;
`else
  assign bus.perf_groups    = '0;
  assign bus.perf_stalls    = '0;
  assign bus.perf_redirects = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit (FETCH_W=2, ADDR_W=10).
module tb_if_fetch_unit;
  localparam int unsigned AW = 10;
  localparam int unsigned IW = 32;
  localparam int unsigned FW = 2;
`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  if_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW), .FETCH_W(FW)) bus ();

  if_fetch_unit #(
    .ADDR_W  (AW),
    .INSTR_W (IW),
    .FETCH_W (FW),
    .NOP_WORD(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic          start;
    logic [AW-1:0] last;
    logic          redir;
    logic [AW-1:0] rpc;
    logic          stall;
    logic [2*IW-1:0] e_instr;
    logic [FW-1:0] e_valid;
    logic          e_chk_pc;
    logic [AW-1:0] e_pc;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t vecs [31];

  function automatic vec_t mk(input logic st, input logic [AW-1:0] last, input logic rd,
                              input logic [AW-1:0] rpc, input logic sl, input logic [IW-1:0] s0,
                              input logic [IW-1:0] s1, input logic [FW-1:0] val, input logic cp,
                              input logic [AW-1:0] pc, input logic bz, input logic dn);
    vec_t v;
    v.start = st; v.last = last; v.redir = rd; v.rpc = rpc; v.stall = sl;
    v.e_instr = {s0, s1}; v.e_valid = val; v.e_chk_pc = cp; v.e_pc = pc;
    v.e_busy = bz; v.e_done = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
    bus.load_en = 1'b1; bus.load_addr = a; bus.instr_in = d;
    @(posedge clk); @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  // Each entry is one cycle: drive at negedge, clock, compare at the next negedge.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.start = vecs[i].start; bus.last_addr = vecs[i].last;
      bus.redirect = vecs[i].redir; bus.redirect_pc = vecs[i].rpc; bus.stall = vecs[i].stall;
      @(posedge clk); @(negedge clk);
      bus.start = 1'b0; bus.redirect = 1'b0; bus.stall = 1'b0;
      chk($sformatf("v%0d instr", i), 64'(bus.instr_out), 64'(vecs[i].e_instr));
      chk($sformatf("v%0d valid", i), 64'(bus.slot_valid), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d busy", i), 64'(bus.busy), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d done", i), 64'(bus.done), 64'(vecs[i].e_done));
      if (vecs[i].e_chk_pc) chk($sformatf("v%0d pc", i), 64'(bus.pc_out), 64'(vecs[i].e_pc));
    end
  endtask

  task automatic chk_perf(input string nm, input int g, input int s, input int r);
    chk({nm, " groups"}, 64'(bus.perf_groups), PERF ? 64'(g) : 64'd0);
    chk({nm, " stalls"}, 64'(bus.perf_stalls), PERF ? 64'(s) : 64'd0);
    chk({nm, " redirects"}, 64'(bus.perf_redirects), PERF ? 64'(r) : 64'd0);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, " instr"}, 64'(bus.instr_out), 64'd0);
    chk({nm, " valid"}, 64'(bus.slot_valid), 64'd0);
    chk({nm, " pc"}, 64'(bus.pc_out), 64'd0);
    chk({nm, " busy"}, 64'(bus.busy), 64'd0);
    chk({nm, " done"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    // start/last/redir/rpc/stall | slot0 slot1 valid chk_pc pc busy done
    vecs[0]  = mk(1, 7, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 1, 2, 2'b11, 1, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 3, 4, 2'b11, 1, 2, 1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 5, 6, 2'b11, 1, 4, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 7, 8, 2'b11, 1, 6, 1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    vecs[6]  = mk(1, 4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 2, 2'b11, 1, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 3, 4, 2'b11, 1, 2, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 5, 0, 2'b01, 1, 4, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    vecs[11] = mk(1, 7, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 1, 2, 2'b11, 1, 0, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 3, 4, 2'b11, 1, 2, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 3, 4, 2'b11, 1, 2, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 1, 3, 4, 2'b11, 1, 2, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 1, 3, 4, 2'b11, 1, 2, 1, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 32'hA, 32'hB, 2'b11, 1, 4, 1, 0);
    vecs[18] = mk(0, 0, 1, 5, 0, 0, 32'hB, 2'b10, 1, 4, 1, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 7, 8, 2'b11, 1, 6, 1, 0);
    vecs[20] = mk(0, 0, 1, 3, 1, 0, 4, 2'b10, 1, 2, 1, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 32'hA, 32'hB, 2'b11, 1, 4, 1, 0);
    vecs[22] = mk(0, 0, 1, 9, 1, 0, 0, 2'b00, 1, 8, 1, 0);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    vecs[24] = mk(1, 7, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    vecs[25] = mk(0, 0, 0, 0, 0, 1, 2, 2'b11, 1, 0, 1, 0);
    vecs[26] = mk(0, 0, 0, 0, 0, 3, 4, 2'b11, 1, 2, 1, 0);
    vecs[27] = mk(0, 0, 0, 0, 0, 32'hA, 32'hB, 2'b11, 1, 4, 1, 0);
    vecs[28] = mk(0, 0, 0, 0, 0, 7, 8, 2'b11, 1, 6, 1, 0);
    vecs[29] = mk(0, 0, 0, 0, 1, 7, 8, 2'b11, 1, 6, 1, 0);
    vecs[30] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);

    bus.load_en = 1'b0; bus.load_addr = '0; bus.instr_in = '0; bus.start = 1'b0;
    bus.last_addr = '0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.stall = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk_cleared("reset");
    chk_perf("reset", 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) load(AW'(i), IW'(i + 1));
    run_vecs(0, 10);
    load(4, 32'hA);
    load(5, 32'hB);
    run_vecs(11, 23);
    chk_perf("sec3", 8, 3, 3);

    // Loads attempted while running must be dropped.
    run_vecs(24, 24);
    bus.load_en = 1'b1; bus.load_addr = '0; bus.instr_in = 32'hDEAD;
    run_vecs(25, 27);
    bus.load_en = 1'b0;
    run_vecs(28, 30);
    chk_perf("sec4", 4, 1, 0);
    run_vecs(11, 13);

    #2 rst = 1'b0;
    #1 chk_cleared("midrun_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_vecs(11, 13);
    chk_perf("after_rst", 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
